// File: rtl/puf_cnt_pkg.sv
// Shared types for the multi-channel edge counter: FSM states and the
// default per-channel count type.
package puf_cnt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Channel counts are WIDTH bits wide; this is the width used when WIDTH is not overridden.
   localparam int unsigned CNT_W_DEFAULT = 16;
   typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for one asynchronous line followed by a registered
// rising-edge detector that produces a one-clock pulse.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic edge_pulse
);

   logic meta;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta       <= 1'b0;
         sync_q     <= 1'b0;
         prev_q     <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         meta       <= async_in;
         sync_q     <= meta;
         prev_q     <= sync_q;
         edge_pulse <= sync_q & ~prev_q;
      end
   end

endmodule

// File: rtl/multi_edge_counter.sv
// Counts synchronized rising edges on N_CH asynchronous lines over a
// programmable window, with wrap or saturate behaviour on overflow.
module multi_edge_counter
   import puf_cnt_pkg::*;
#(
   parameter int unsigned N_CH      = 2,
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned WIN_W     = 16,
   parameter int unsigned AUTORESET = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WIN_W-1:0]      win_len,
   input  logic [N_CH-1:0]       ev_in,
   output logic                  busy,
   output logic                  done,
   output logic [N_CH*WIDTH-1:0] cnt,
   output logic [N_CH-1:0]       at_max
);

   state_t           state;
   state_t           state_nx;
   logic [WIN_W-1:0] win_cnt;
   logic [WIN_W-1:0] win_nx;
   logic             clear;
   logic [N_CH-1:0]  pulse;
   logic [WIDTH-1:0] cnt_r [N_CH];

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      edge_sync u_sync (
         .clk        (clk),
         .rst        (rst),
         .async_in   (ev_in[g]),
         .edge_pulse (pulse[g])
      );
      assign cnt[g*WIDTH +: WIDTH] = cnt_r[g];
   end

   always_comb begin
      state_nx = state;
      win_nx   = win_cnt;
      clear    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clear = 1'b1;
               if (win_len != '0) begin
                  state_nx = COUNT;
                  win_nx   = win_len;
               end else begin
                  state_nx = DONE;
               end
            end
         end
         COUNT: begin
            win_nx = win_cnt - 1'b1;
            // abort outranks expiry so an aborted window never pulses done
            if (abort) begin
               state_nx = IDLE;
            end else if (win_cnt == WIN_W'(1)) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         win_cnt <= '0;
      end else begin
         state   <= state_nx;
         win_cnt <= win_nx;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (rst || clear) begin
            cnt_r[i]  <= '0;
            at_max[i] <= 1'b0;
         end else if (state == COUNT && pulse[i]) begin
            if (cnt_r[i] == '1) begin
               at_max[i] <= 1'b1;
               if (AUTORESET != 0) begin
                  cnt_r[i] <= '0;
               end
            end else begin
               cnt_r[i] <= cnt_r[i] + 1'b1;
            end
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_multi_edge_counter.sv
// Self-checking bench: a 16-bit wrapping, a 4-bit wrapping and a 4-bit
// saturating counter share one stimulus stream.
module tb_multi_edge_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] win_len;
   logic [1:0]  ev_in;

   logic        busy_a, done_a, busy_w, done_w, busy_s, done_s;
   logic [31:0] cnt_a;
   logic [7:0]  cnt_w, cnt_s;
   logic [1:0]  am_a, am_w, am_s;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   typedef struct {
      int unsigned win_len, n0, n1;
      int unsigned a0, a1, w0, w1, s0, s1;
      int unsigned am_a, am_w, am_s;
   } vec_t;

   vec_t vecs [4];
   vec_t sb [$];

   always #5 clk = ~clk;

   multi_edge_counter #(.N_CH(2), .WIDTH(16), .WIN_W(16), .AUTORESET(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
      .ev_in(ev_in), .busy(busy_a), .done(done_a), .cnt(cnt_a), .at_max(am_a));

   multi_edge_counter #(.N_CH(2), .WIDTH(4), .WIN_W(16), .AUTORESET(1)) dut_w (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
      .ev_in(ev_in), .busy(busy_w), .done(done_w), .cnt(cnt_w), .at_max(am_w));

   multi_edge_counter #(.N_CH(2), .WIDTH(4), .WIN_W(16), .AUTORESET(0)) dut_s (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
      .ev_in(ev_in), .busy(busy_s), .done(done_s), .cnt(cnt_s), .at_max(am_s));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".busy"}, {busy_a, busy_w, busy_s}, 0);
      check({tag, ".done"}, {done_a, done_w, done_s}, 0);
      check({tag, ".cnt_a"}, cnt_a, 0);
      check({tag, ".cnt_ws"}, {cnt_w, cnt_s}, 0);
      check({tag, ".at_max"}, {am_a, am_w, am_s}, 0);
   endtask

   task automatic compare_vec(input string tag, input vec_t e);
      check({tag, ".a0"}, cnt_a[15:0], e.a0);
      check({tag, ".a1"}, cnt_a[31:16], e.a1);
      check({tag, ".w0"}, cnt_w[3:0], e.w0);
      check({tag, ".w1"}, cnt_w[7:4], e.w1);
      check({tag, ".s0"}, cnt_s[3:0], e.s0);
      check({tag, ".s1"}, cnt_s[7:4], e.s1);
      check({tag, ".am_a"}, am_a, e.am_a);
      check({tag, ".am_w"}, am_w, e.am_w);
      check({tag, ".am_s"}, am_s, e.am_s);
   endtask

   // One full window: n0/n1 rising edges spaced two cycles apart, all well inside the window.
   task automatic run_window(input string tag, input vec_t v);
      int unsigned t, m;
      vec_t e;
      ev_in = '0;
      repeat (4) tick();
      win_len = v.win_len[15:0];
      start   = 1'b1;
      sb.push_back(v);
      tick();
      start = 1'b0;
      t = 1;
      m = (v.n0 > v.n1) ? v.n0 : v.n1;
      for (int unsigned k = 0; k < m; k++) begin
         ev_in[0] = (k < v.n0);
         ev_in[1] = (k < v.n1);
         tick();
         ev_in = '0;
         tick();
         t += 2;
      end
      while (done_a !== 1'b1 && t < 200) begin
         tick();
         t++;
      end
      check({tag, ".latency"}, t, v.win_len + 1);
      check({tag, ".done_ws"}, {done_w, done_s}, 2'b11);
      e = sb.pop_front();
      compare_vec(tag, e);
      tick();
      check({tag, ".done_pulse"}, {done_a, busy_a}, 0);
      for (int unsigned k = 0; k < 3; k++) begin
         ev_in = 2'b11;
         tick();
         ev_in = '0;
         tick();
      end
      repeat (5) tick();
      compare_vec({tag, ".held"}, e);
   endtask

   initial begin
      int unsigned t;
      logic        seen;

      vecs[0] = '{16, 5, 3, 5, 3, 5, 3, 5, 3, 0, 0, 0};
      vecs[1] = '{42, 18, 0, 18, 0, 2, 0, 15, 0, 0, 1, 1};
      vecs[2] = '{40, 15, 16, 15, 16, 15, 0, 15, 15, 0, 2, 2};
      vecs[3] = '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

      rst = 1'b1; start = 1'b0; abort = 1'b0; win_len = '0; ev_in = '0;
      repeat (2) tick();
      check_zero("reset");
      rst = 1'b0;

      for (int unsigned i = 0; i < 4; i++) begin
         run_window($sformatf("vec%0d", i), vecs[i]);
      end

      // Events already toggling before start; window of 10 sees exactly 5 pulses.
      ev_in = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         ev_in[0] = ~ev_in[0];
         tick();
      end
      start = 1'b1; win_len = 16'd10; ev_in[0] = ~ev_in[0];
      tick();
      start = 1'b0;
      t = 1;
      while (done_a !== 1'b1 && t < 40) begin
         ev_in[0] = ~ev_in[0];
         tick();
         t++;
      end
      check("win10.latency", t, 11);
      check("win10.cnt0", cnt_a[15:0], 5);
      check("win10.cnt1", cnt_a[31:16], 0);
      check("win10.cnt_w0", cnt_w[3:0], 5);
      ev_in = '0;

      // Zero-length window, start held into DONE must not re-arm.
      repeat (4) tick();
      start = 1'b1; win_len = 16'd0;
      tick();
      check("w0.busy_done", {busy_a, done_a}, 2'b11);
      check("w0.cnt", cnt_a, 0);
      tick();
      start = 1'b0;
      check("w0.after", {busy_a, done_a, busy_s, done_s}, 0);
      tick();
      check("w0.idle", {busy_a, done_a}, 0);

      // Abort on cycle 4 of a 20-cycle window, with a start attempt while busy.
      repeat (3) tick();
      start = 1'b1; win_len = 16'd20;
      tick();
      ev_in[0] = 1'b1; win_len = 16'd2;
      tick();
      check("ab.c1", {busy_a, done_a}, 2'b10);
      start = 1'b0; win_len = 16'd20; ev_in[0] = 1'b0;
      tick();
      check("ab.c2", done_a, 0);
      ev_in[0] = 1'b1;
      tick();
      check("ab.c3", {done_a, done_w}, 0);
      ev_in[0] = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab.busy_done", {busy_a, done_a, busy_s, done_s}, 0);
      check("ab.cnt0", cnt_a[15:0], 1);
      seen = 1'b0;
      for (int unsigned k = 0; k < 25; k++) begin
         ev_in[0] = ~ev_in[0];
         tick();
         seen = seen | done_a | busy_a;
      end
      ev_in = '0;
      check("ab.no_done", seen, 0);
      check("ab.frozen", cnt_a[15:0], 1);

      // Reset in IDLE clears sticky at_max.
      run_window("vec1b", vecs[1]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("rst_idle");

      // Reset on cycle 5 of a running window.
      repeat (4) tick();
      start = 1'b1; win_len = 16'd30;
      tick();
      start = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         ev_in[0] = ~ev_in[0];
         tick();
      end
      check("rw.pre", cnt_a[15:0], 1);
      rst = 1'b1;
      tick();
      rst = 1'b0; ev_in = '0;
      check_zero("rw.post");
      seen = 1'b0;
      for (int unsigned k = 0; k < 40; k++) begin
         tick();
         seen = seen | done_a | busy_a;
      end
      check("rw.no_done", seen, 0);

      // Abort lands on the same cycle the window would expire.
      start = 1'b1; win_len = 16'd5;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("ax.busy", busy_a, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ax.after", {busy_a, done_a, done_w, done_s}, 0);
      seen = 1'b0;
      for (int unsigned k = 0; k < 5; k++) begin
         tick();
         seen = seen | done_a;
      end
      check("ax.no_done", seen, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
